bsg_cgol_job_sched: RTL and testbench
=====================================

Name: bsg_cgol_job_sched

Overview:
- Two-client job scheduler in front of the single decryptor engine (input channel, ctrl, cell array, output channel).
- Grants the engine to one client at a time using round-robin, and forwards that client's input words into the engine.
- Routes the engine's result words back to the same client, then releases the engine.
- Only one job is in flight at a time; a grant is held from the first input word until the last output word.

Parameters:
- num_clients_p, 2, number of requesters; supported values are 2..4.
- in_words_p, 2, 64-bit words per job sent into the engine (board words plus frames word).
- out_words_p, 1, 64-bit result words per job returned from the engine.
- client_id_width_lp, `BSG_SAFE_CLOG2(num_clients_p), localparam.
- in_cnt_width_lp, `BSG_SAFE_CLOG2(in_words_p+1), localparam.
- out_cnt_width_lp, `BSG_SAFE_CLOG2(out_words_p+1), localparam.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- cl_data_i  in  num_clients_p*64  per-client job words; client k uses bits [64k+63:64k].
- cl_v_i  in  num_clients_p  per-client input valid.
- cl_ready_o  out  num_clients_p  per-client input ready.
- cl_data_o  out  64  result word, shared by all clients; meaningful only where cl_v_o is set.
- cl_v_o  out  num_clients_p  per-client result valid; one-hot or zero.
- cl_yumi_i  in  num_clients_p  per-client result consume.
- eng_data_o  out  64  word to engine input.
- eng_v_o  out  1  engine input valid.
- eng_ready_i  in  1  engine input ready.
- eng_data_i  in  64  engine result word.
- eng_v_i  in  1  engine result valid.
- eng_yumi_o  out  1  engine result consume.
- owner_o  out  client_id_width_lp  currently granted client; 0 when idle.
- busy_o  out  1  asserted in any state other than IDLE.

Behaviour:
- States: IDLE, FWD_IN, FWD_OUT. State changes and all registers update on clk_i.
- Reset (synchronous, reset_i=1):
  - state=IDLE, owner=0, last_grant=num_clients_p-1 (so client 0 wins first), both counters=0.
  - All outputs 0 during the reset cycle and the cycle after.
  - Reset mid-job abandons the job with no flush; engine cleanup is the engine's own reset.
- IDLE:
  - cl_ready_o=0, eng_v_o=0, eng_yumi_o=0, cl_v_o=0.
  - If any cl_v_i is set, owner <= first requesting client searching upward (with wrap) from last_grant+1; last_grant <= owner; next state FWD_IN.
  - No data moves in the grant cycle. Grant-to-first-transfer latency is 1 cycle minimum.
- FWD_IN (combinational pass-through, no added latency):
  - eng_data_o = cl_data_i[owner]; eng_v_o = cl_v_i[owner].
  - cl_ready_o[owner] = eng_ready_i; all other cl_ready_o bits are 0.
  - Transfer occurs when cl_v_i[owner] & eng_ready_i; in_cnt increments on each transfer.
  - On the transfer that makes in_cnt == in_words_p: in_cnt <= 0, next state FWD_OUT.
  - eng_yumi_o=0 here; any early eng_v_i is held off, not dropped.
- FWD_OUT:
  - cl_data_o = eng_data_i; cl_v_o[owner] = eng_v_i.
  - eng_yumi_o = eng_v_i & cl_yumi_i[owner].
  - cl_yumi_i from non-owners is ignored.
  - out_cnt increments on each eng_yumi_o.
  - On the consume that makes out_cnt == out_words_p: out_cnt <= 0, next state IDLE.
  - Back-to-back jobs: IDLE lasts exactly 1 cycle when requests are pending.
- Fairness:
  - With all clients continuously requesting, grants rotate 0,1,..,N-1,0.
  - A lone requester is re-granted every job.
- A client that deasserts cl_v_i mid-job stalls the engine indefinitely; there is no timeout. This is legal.
- cl_v_i changes from non-owners during a job have no effect on state.

Optional Feature:
- Macro: BSG_CGOL_JOB_SCHED_PERF_EN.
- Enabled:
  - Adds output port jobs_done_o, num_clients_p*16 bits.
  - One 16-bit saturating counter per client, incremented when that client's job leaves FWD_OUT.
  - Counters clear on reset_i.
  - Saturation holds at 16'hFFFF.
- Disabled: port and counters are absent. All other behaviour is identical.

Test Plan:
- Single job: reset, then client0 sends 2 words 0xA5A5_0000_0000_0001 and 0x0000_0000_0000_0003 with eng_ready_i=1, then engine returns 0xDEAD_BEEF_0000_0000 → words reach eng_data_o in order; cl_v_o=2'b01 with that data; busy_o falls 1 cycle after cl_yumi_i[0].
- Contention: cl_v_i=2'b11 held for 4 jobs → owner_o sequence 0,1,0,1; cl_ready_o is never 2'b11.
- Backpressure: toggle eng_ready_i every cycle, and hold cl_yumi_i[1]=0 for 5 cycles while client1 owns the engine → no words lost or duplicated, eng_yumi_o stays 0 until cl_yumi_i[1]=1.
- Early engine output: drive eng_v_i=1 during FWD_IN → eng_yumi_o=0 and cl_v_o=0 until the state reaches FWD_OUT.
- Reset mid-job: assert reset_i after 1 of 2 input words → state IDLE, busy_o=0, owner_o=0; next grant with both requesting goes to client 0.
- With BSG_CGOL_JOB_SCHED_PERF_EN defined: 3 jobs by client1 and 1 job by client0 → jobs_done_o = {16'd3, 16'd1}.

Source files
------------

// File: rtl/bsg_cgol_job_sched.sv
// bsg_cgol_job_sched: round-robin scheduler that lends the single decryptor
// engine to one client per job. The owner's input words pass straight into
// the engine, the engine's result words pass straight back to the owner, and
// the grant is held from the first input word until the last result word.
//
// Handshakes: a word moves on an input channel when valid & ready are both
// high in the same cycle; a result word is consumed when valid & yumi are
// both high. Valid never waits on ready/yumi.
//
// Optional build macro BSG_CGOL_JOB_SCHED_PERF_EN adds jobs_done_o, one
// 16-bit saturating completed-job counter per client.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_cgol_job_sched #(
    parameter int num_clients_p = 2,
    parameter int in_words_p    = 2,
    parameter int out_words_p   = 1,
    localparam int client_id_width_lp = `BSG_SAFE_CLOG2(num_clients_p),
    localparam int in_cnt_width_lp    = `BSG_SAFE_CLOG2(in_words_p + 1),
    localparam int out_cnt_width_lp   = `BSG_SAFE_CLOG2(out_words_p + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [num_clients_p*64-1:0]   cl_data_i,
    input  logic [num_clients_p-1:0]      cl_v_i,
    output logic [num_clients_p-1:0]      cl_ready_o,
    output logic [63:0]                   cl_data_o,
    output logic [num_clients_p-1:0]      cl_v_o,
    input  logic [num_clients_p-1:0]      cl_yumi_i,
    output logic [63:0]                   eng_data_o,
    output logic                          eng_v_o,
    input  logic                          eng_ready_i,
    input  logic [63:0]                   eng_data_i,
    input  logic                          eng_v_i,
    output logic                          eng_yumi_o,
    output logic [client_id_width_lp-1:0] owner_o,
    output logic                          busy_o
`ifdef BSG_CGOL_JOB_SCHED_PERF_EN
    ,
    output logic [num_clients_p*16-1:0]   jobs_done_o
`endif
);

    typedef enum logic [1:0] {IDLE, FWD_IN, FWD_OUT} state_e;

    state_e                        state_q, state_d;
    logic [client_id_width_lp-1:0] owner_q, owner_d;
    logic [client_id_width_lp-1:0] last_grant_q, last_grant_d;
    logic [in_cnt_width_lp-1:0]    in_cnt_q, in_cnt_d;
    logic [out_cnt_width_lp-1:0]   out_cnt_q, out_cnt_d;

    logic                          grant_found;
    logic [client_id_width_lp-1:0] grant_id;
    logic [63:0]                   owner_data;
    logic                          in_xfer;
    logic                          out_xfer;
    int                            cand;

    // Round-robin pick: first requester searching upward from last_grant+1.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = last_grant_q;
        cand        = 0;
        for (int i = 1; i <= num_clients_p; i++) begin
            cand = (int'(last_grant_q) + i) % num_clients_p;
            if (!grant_found && cl_v_i[client_id_width_lp'(cand)]) begin
                grant_found = 1'b1;
                grant_id    = client_id_width_lp'(cand);
            end
        end
    end

    // Select the owner's input word.
    always_comb begin
        owner_data = '0;
        for (int k = 0; k < num_clients_p; k++) begin
            if (owner_q == client_id_width_lp'(k)) begin
                owner_data = cl_data_i[k*64 +: 64];
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= client_id_width_lp'(num_clients_p - 1);
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    // Next-state and output decode; every output is forced low while reset_i is high.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        cl_ready_o   = '0;
        cl_data_o    = '0;
        cl_v_o       = '0;
        eng_data_o   = '0;
        eng_v_o      = 1'b0;
        eng_yumi_o   = 1'b0;
        owner_o      = '0;
        busy_o       = 1'b0;
        in_xfer      = 1'b0;
        out_xfer     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    in_cnt_d     = '0;
                    out_cnt_d    = '0;
                    state_d      = FWD_IN;
                end
            end
            FWD_IN: begin
                busy_o              = 1'b1;
                owner_o             = owner_q;
                eng_data_o          = owner_data;
                eng_v_o             = cl_v_i[owner_q];
                cl_ready_o[owner_q] = eng_ready_i;
                in_xfer             = cl_v_i[owner_q] & eng_ready_i;
                if (in_xfer) begin
                    if (in_cnt_q == in_cnt_width_lp'(in_words_p - 1)) begin
                        in_cnt_d = '0;
                        state_d  = FWD_OUT;
                    end else begin
                        in_cnt_d = in_cnt_q + in_cnt_width_lp'(1);
                    end
                end
            end
            FWD_OUT: begin
                busy_o          = 1'b1;
                owner_o         = owner_q;
                cl_data_o       = eng_data_i;
                cl_v_o[owner_q] = eng_v_i;
                out_xfer        = eng_v_i & cl_yumi_i[owner_q];
                eng_yumi_o      = out_xfer;
                if (out_xfer) begin
                    if (out_cnt_q == out_cnt_width_lp'(out_words_p - 1)) begin
                        out_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + out_cnt_width_lp'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset_i) begin
            cl_ready_o = '0;
            cl_data_o  = '0;
            cl_v_o     = '0;
            eng_data_o = '0;
            eng_v_o    = 1'b0;
            eng_yumi_o = 1'b0;
            owner_o    = '0;
            busy_o     = 1'b0;
        end
    end

`ifdef BSG_CGOL_JOB_SCHED_PERF_EN
    logic [15:0] jobs_q [num_clients_p];
    logic        job_done;

    // A job completes on the final result consume.
    always_comb begin
        job_done = (state_q == FWD_OUT) && eng_yumi_o &&
                   (out_cnt_q == out_cnt_width_lp'(out_words_p - 1));
    end

    // Per-client saturating completed-job counters.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < num_clients_p; k++) begin
            if (reset_i) begin
                jobs_q[k] <= '0;
            end else if (job_done && (owner_q == client_id_width_lp'(k)) &&
                         (jobs_q[k] != 16'hFFFF)) begin
                jobs_q[k] <= jobs_q[k] + 16'd1;
            end
        end
    end

    // Pack counters onto the output, zero while reset_i is high.
    always_comb begin
        jobs_done_o = '0;
        for (int k = 0; k < num_clients_p; k++) begin
            jobs_done_o[k*16 +: 16] = reset_i ? 16'h0 : jobs_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_bsg_cgol_job_sched.sv
// Self-checking bench for bsg_cgol_job_sched (2 clients, 2 words in, 1 out).
// A job-level reference model tracks owner / words sent / words returned and
// predicts every output each cycle; directed scenarios add literal checks.
// Build with BSG_CGOL_JOB_SCHED_PERF_EN to also check the job counters.

module tb_bsg_cgol_job_sched;

    localparam int N  = 2;
    localparam int IW = 2;
    localparam int OW = 1;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*64-1:0] cl_data = '0;
    logic [N-1:0]    cl_v    = '0;
    logic [N-1:0]    cl_yumi = '0;
    logic            eng_ready = 1'b0;
    logic            eng_v     = 1'b0;
    logic [63:0]     eng_data  = '0;

    logic [N-1:0]    cl_ready_o;
    logic [63:0]     cl_data_o;
    logic [N-1:0]    cl_v_o;
    logic [63:0]     eng_data_o;
    logic            eng_v_o;
    logic            eng_yumi_o;
    logic [0:0]      owner_o;
    logic            busy_o;
`ifdef BSG_CGOL_JOB_SCHED_PERF_EN
    logic [N*16-1:0] jobs_done;
`endif

    bsg_cgol_job_sched #(.num_clients_p(N), .in_words_p(IW), .out_words_p(OW)) dut (
        .clk_i(clk),
        .reset_i(rst),
        .cl_data_i(cl_data),
        .cl_v_i(cl_v),
        .cl_ready_o(cl_ready_o),
        .cl_data_o(cl_data_o),
        .cl_v_o(cl_v_o),
        .cl_yumi_i(cl_yumi),
        .eng_data_o(eng_data_o),
        .eng_v_o(eng_v_o),
        .eng_ready_i(eng_ready),
        .eng_data_i(eng_data),
        .eng_v_i(eng_v),
        .eng_yumi_o(eng_yumi_o),
        .owner_o(owner_o),
        .busy_o(busy_o)
`ifdef BSG_CGOL_JOB_SCHED_PERF_EN
        ,
        .jobs_done_o(jobs_done)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: job-level view of the scheduler
    bit          mon_en     = 1'b1;
    bit          m_busy     = 1'b0;
    int          m_owner    = 0;
    int          m_last     = N - 1;
    int          m_sent     = 0;
    int          m_ret      = 0;
    bit          m_post_rst = 1'b0;
    int          m_jobs [N];
    int          cyc        = 0;
    bit          prev_busy  = 1'b0;
    int          grant_log[$];
    int          grant_cyc[$];
    int          dut_glog[$];
    logic [63:0] eng_log[$];
    logic [63:0] exp_q[$];

    // Compare process: predicts outputs from the model, checks them, then advances the model
    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic [N-1:0] e_clv;
        logic         e_ev;
        logic         e_yumi;
        logic         e_busy;
        int           e_own;
        int           c;
        if (mon_en) begin
            cyc++;
            e_ready = '0; e_clv = '0; e_ev = 1'b0; e_yumi = 1'b0; e_busy = 1'b0; e_own = 0;
            if (rst || m_post_rst) begin
                check("rst_eng_data", eng_data_o, 64'h0);
                check("rst_cl_data", cl_data_o, 64'h0);
            end else if (m_busy && m_sent < IW) begin
                e_busy = 1'b1; e_own = m_owner;
                e_ev = cl_v[m_owner];
                e_ready[m_owner] = eng_ready;
                check("eng_data", eng_data_o, cl_data[m_owner*64 +: 64]);
            end else if (m_busy) begin
                e_busy = 1'b1; e_own = m_owner;
                e_clv[m_owner] = eng_v;
                e_yumi = eng_v & cl_yumi[m_owner];
                if (e_clv != '0) check("cl_data", cl_data_o, eng_data);
            end
            check("cl_ready", 64'(cl_ready_o), 64'(e_ready));
            check("cl_v", 64'(cl_v_o), 64'(e_clv));
            check("eng_v", 64'(eng_v_o), 64'(e_ev));
            check("eng_yumi", 64'(eng_yumi_o), 64'(e_yumi));
            check("busy", 64'(busy_o), 64'(e_busy));
            check("owner", 64'(owner_o), 64'(e_own));
`ifdef BSG_CGOL_JOB_SCHED_PERF_EN
            for (int k = 0; k < N; k++) begin
                check("jobs_done", 64'(jobs_done[k*16 +: 16]),
                      (rst || m_post_rst) ? 64'h0 : 64'(m_jobs[k] > 65535 ? 65535 : m_jobs[k]));
            end
`endif
            // Scoreboard: every accepted client word must appear once, in order, at the engine
            for (int k = 0; k < N; k++) begin
                if (cl_v[k] && cl_ready_o[k]) exp_q.push_back(cl_data[k*64 +: 64]);
            end
            if (eng_v_o && eng_ready) begin
                eng_log.push_back(eng_data_o);
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_extra: engine took %h with no client word accepted", eng_data_o);
                end else begin
                    check("sb_word", eng_data_o, exp_q.pop_front());
                end
            end
            if (busy_o && !prev_busy) dut_glog.push_back(int'(owner_o));
            prev_busy = busy_o;

            // Advance model to the state after the coming rising edge
            if (rst) begin
                m_busy = 1'b0; m_last = N - 1; m_post_rst = 1'b1;
                for (int k = 0; k < N; k++) m_jobs[k] = 0;
            end else begin
                m_post_rst = 1'b0;
                if (!m_busy) begin
                    if (cl_v != '0) begin
                        for (int i = N; i >= 1; i--) begin
                            c = (m_last + i) % N;
                            if (cl_v[c]) m_owner = c;
                        end
                        m_last = m_owner; m_busy = 1'b1; m_sent = 0; m_ret = 0;
                        grant_log.push_back(m_owner);
                        grant_cyc.push_back(cyc);
                    end
                end else if (m_sent < IW) begin
                    if (cl_v[m_owner] && eng_ready) m_sent++;
                end else if (eng_v && cl_yumi[m_owner]) begin
                    m_ret++;
                    if (m_ret == OW) begin
                        m_busy = 1'b0;
                        m_jobs[m_owner]++;
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cl_v = '0; cl_yumi = '0; eng_v = 1'b0; eng_ready = 1'b0;
        cl_data = '0; eng_data = '0;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_busy", 64'(busy_o), 64'h0);
        check("post_rst_owner", 64'(owner_o), 64'h0);
    endtask

    task automatic run_lone_job(input int c);
        cl_v = '0; cl_v[c] = 1'b1;
        cl_yumi = '0; cl_yumi[c] = 1'b1;
        eng_ready = 1'b1; eng_v = 1'b1; eng_data = {$urandom, $urandom};
        cl_data[c*64 +: 64] = {$urandom, $urandom};
        repeat (4) tick();
        cl_v = '0; cl_yumi = '0; eng_v = 1'b0; eng_ready = 1'b0;
        tick();
    endtask

    logic [63:0] w [2];
    int          idx;
    int          bud;
    logic        tog;

    initial begin
        for (int k = 0; k < N; k++) m_jobs[k] = 0;

        // Single job with literal data
        do_reset();
        eng_log.delete();
        cl_data[63:0] = 64'hA5A5_0000_0000_0001; cl_v = 2'b01; eng_ready = 1'b1;
        tick();
        check("t1_ready", 64'(cl_ready_o), 64'h1);
        check("t1_w0", eng_data_o, 64'hA5A5_0000_0000_0001);
        tick();
        cl_data[63:0] = 64'h0000_0000_0000_0003;
        tick();
        cl_v = 2'b00; eng_ready = 1'b0; eng_v = 1'b1; eng_data = 64'hDEAD_BEEF_0000_0000;
        #1;
        check("t1_clv", 64'(cl_v_o), 64'h1);
        check("t1_cldata", cl_data_o, 64'hDEAD_BEEF_0000_0000);
        check("t1_busy_hold", 64'(busy_o), 64'h1);
        check("t1_yumi_wait", 64'(eng_yumi_o), 64'h0);
        cl_yumi = 2'b01;
        #1;
        check("t1_yumi", 64'(eng_yumi_o), 64'h1);
        tick();
        cl_yumi = '0; eng_v = 1'b0;
        #1;
        check("t1_busy_fall", 64'(busy_o), 64'h0);
        check("t1_nwords", 64'(eng_log.size()), 64'd2);
        if (eng_log.size() == 2) begin
            check("t1_log0", eng_log[0], 64'hA5A5_0000_0000_0001);
            check("t1_log1", eng_log[1], 64'h0000_0000_0000_0003);
        end

        // Contention: both clients request continuously
        do_reset();
        grant_log.delete(); grant_cyc.delete(); dut_glog.delete();
        cl_v = 2'b11; eng_ready = 1'b1; eng_v = 1'b1; cl_yumi = 2'b11;
        bud = 0;
        while (grant_log.size() < 5 && bud < 100) begin
            cl_data = {$urandom, $urandom, $urandom, $urandom};
            eng_data = {$urandom, $urandom};
            tick();
            bud++;
        end
        cl_v = '0; eng_v = 1'b0; cl_yumi = '0;
        check("t2_ngrants", 64'(grant_log.size()), 64'd5);
        if (grant_log.size() >= 5 && dut_glog.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_model_grant", 64'(grant_log[i]), 64'(i % 2));
                check("t2_dut_grant", 64'(dut_glog[i]), 64'(i % 2));
            end
            for (int i = 0; i < 3; i++) begin
                check("t2_job_period", 64'(grant_cyc[i+1] - grant_cyc[i]), 64'd4);
            end
        end else begin
            check("t2_dut_ngrants", 64'(dut_glog.size()), 64'd4);
        end

        // Backpressure on both sides with client 1
        do_reset();
        eng_log.delete();
        w[0] = {$urandom, $urandom}; w[1] = {$urandom, $urandom};
        idx = 0; bud = 0; tog = 1'b0; cl_v = 2'b10;
        while (idx < 2 && bud < 40) begin
            cl_data[127:64] = w[idx];
            eng_ready = tog; tog = ~tog;
            #1;
            if (cl_ready_o[1]) idx++;
            tick();
            bud++;
        end
        check("t3_in_done", 64'(idx), 64'd2);
        cl_v = '0; eng_ready = 1'b0; eng_v = 1'b1; eng_data = {$urandom, $urandom};
        cl_yumi = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_yumi_hold", 64'(eng_yumi_o), 64'h0);
            check("t3_clv_hold", 64'(cl_v_o), 64'h2);
            tick();
        end
        cl_yumi = 2'b10;
        #1;
        check("t3_yumi", 64'(eng_yumi_o), 64'h1);
        tick();
        cl_yumi = '0; eng_v = 1'b0;
        #1;
        check("t3_busy_fall", 64'(busy_o), 64'h0);
        check("t3_nwords", 64'(eng_log.size()), 64'd2);
        if (eng_log.size() == 2) begin
            check("t3_log0", eng_log[0], w[0]);
            check("t3_log1", eng_log[1], w[1]);
        end

        // Early engine output during input phase
        do_reset();
        cl_v = 2'b01; cl_data = {$urandom, $urandom, $urandom, $urandom};
        eng_ready = 1'b0; eng_v = 1'b1; eng_data = {$urandom, $urandom}; cl_yumi = 2'b11;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t4_yumi_held", 64'(eng_yumi_o), 64'h0);
            check("t4_clv_held", 64'(cl_v_o), 64'h0);
            check("t4_busy", 64'(busy_o), 64'h1);
            tick();
        end
        eng_ready = 1'b1;
        tick();
        tick();
        cl_v = '0;
        #1;
        check("t4_clv", 64'(cl_v_o), 64'h1);
        check("t4_yumi", 64'(eng_yumi_o), 64'h1);
        tick();
        eng_v = 1'b0; cl_yumi = '0;
        #1;
        check("t4_busy_fall", 64'(busy_o), 64'h0);

        // Reset after the first of two input words
        do_reset();
        cl_v = 2'b11; eng_ready = 1'b1; cl_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 64'(busy_o), 64'h0);
        check("t5_rst_owner", 64'(owner_o), 64'h0);
        check("t5_rst_ready", 64'(cl_ready_o), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_after_busy", 64'(busy_o), 64'h0);
        check("t5_after_owner", 64'(owner_o), 64'h0);
        tick();
        check("t5_regrant_busy", 64'(busy_o), 64'h1);
        check("t5_regrant_owner", 64'(owner_o), 64'h0);
        cl_v = '0;

        // Randomized traffic, occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cl_v      = N'($urandom_range(0, 3));
            cl_data   = {$urandom, $urandom, $urandom, $urandom};
            eng_ready = 1'($urandom_range(0, 1));
            eng_v     = 1'($urandom_range(0, 1));
            eng_data  = {$urandom, $urandom};
            cl_yumi   = N'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'h0);

`ifdef BSG_CGOL_JOB_SCHED_PERF_EN
        do_reset();
        run_lone_job(0);
        run_lone_job(1);
        run_lone_job(1);
        run_lone_job(1);
        check("perf_jobs", 64'(jobs_done), 64'({16'd3, 16'd1}));
`endif

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
